// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared constants and FSM state type for the DSP result drain
//
// Purpose: default widths of the DSP result path and the drain FSM state enum,
//          imported by dsp_result_drain and dsp_result_fifo2.
// Ports:   none (package).

package dsp_pkg;

  localparam int DSP_RESULT_W = 144;
  localparam int DRAIN_OUT_W  = 36;
  localparam int DRAIN_WORDS  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/dsp_result_fifo2.sv
// rtl/dsp_result_fifo2.sv - two-entry frame buffer for the DSP result drain
//
// Purpose: holds up to two captured {result1, result0} frames in arrival order.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset (empties the buffer)
//   push_i       write push_data_i into the tail slot (ignored when full)
//   push_data_i  frame to store
//   pop_i        drop the head frame (ignored when empty)
//   occupancy_o  registered number of stored frames, 0..2
//   head_o       oldest stored frame

module dsp_result_fifo2
  import dsp_pkg::*;
#(
  parameter int FRAME_W = 2 * DSP_RESULT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [FRAME_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [1:0]         occupancy_o,
  output logic [FRAME_W-1:0] head_o
);

  logic [FRAME_W-1:0] mem_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         occ_q, occ_d;
  logic               push_ok;
  logic               pop_ok;

  // Guard against pushing a full or popping an empty buffer so the
  // occupancy count can never wrap, whatever the caller does.
  assign push_ok = push_i && (occ_q != 2'd2);
  assign pop_ok  = pop_i  && (occ_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    occ_d    = occ_q;
    if (push_ok && !pop_ok) begin
      occ_d = occ_q + 2'd1;
    end else if (!push_ok && pop_ok) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Frame storage carries no reset: stale contents are never visible
  // because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign occupancy_o = occ_q;
  assign head_o      = mem_q[rd_ptr_q];

endmodule

// File: rtl/dsp_result_drain.sv
// rtl/dsp_result_drain.sv - serializes captured DSP result frames into OUT_W words
//
// Purpose: captures {result1, result0} frames into a two-entry buffer and
//          drains each frame as 2*DATA_W/OUT_W words with valid/ready flow
//          control, result0 slices first, lowest slice first.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   capture        sample result0/result1 as one frame this cycle
//   result0        first-half DSP result
//   result1        second-half DSP result
//   capture_ready  a frame slot is free (registered occupancy < 2)
//   out_data       serialized word (0 when idle)
//   out_valid      out_data is valid
//   out_ready      downstream accepts the word
//   out_last       final word of a frame
//   overrun        sticky: a capture was dropped; cleared only by reset
//   frame_count    number of fully drained frames, wrapping

module dsp_result_drain
  import dsp_pkg::*;
#(
  parameter int DATA_W = DSP_RESULT_W,
  parameter int OUT_W  = DRAIN_OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [DATA_W-1:0] result0,
  input  logic [DATA_W-1:0] result1,
  output logic              capture_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overrun,
  output logic [15:0]       frame_count
);

  localparam int N     = (2 * DATA_W) / OUT_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  drain_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       frame_count_q, frame_count_d;

  logic [1:0]        occupancy;
  logic [2*DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              handshake;
  logic              at_last;
  logic [OUT_W-1:0]  words [N];

  dsp_result_fifo2 #(
    .FRAME_W (2 * DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({result1, result0}),
    .pop_i       (pop),
    .occupancy_o (occupancy),
    .head_o      (head)
  );

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = head[i*OUT_W +: OUT_W];
  end

  // Readiness uses only registered occupancy, so a capture arriving while
  // full is dropped even if the same edge pops the last word.
  assign capture_ready = (occupancy != 2'd2);
  assign push          = capture && capture_ready;

  assign out_valid = (state_q == ST_DRAIN);
  assign at_last   = (idx_q == LAST_IDX);
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && at_last;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q | (capture & ~capture_ready);
    unique case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          if (at_last) begin
            idx_d         = '0;
            frame_count_d = frame_count_q + 16'd1;
            // Keep draining when another frame remains after this pop,
            // either already buffered or arriving on this very edge.
            if ((occupancy == 2'd2) || push) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out_data    = out_valid ? words[idx_q] : '0;
  assign out_last    = out_valid && at_last;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_dsp_result_drain.sv
// tb/tb_dsp_result_drain.sv - self-checking bench for dsp_result_drain

module tb_dsp_result_drain;

  logic          clk = 1'b0;
  logic          reset;
  logic          capture;
  logic [143:0]  result0;
  logic [143:0]  result1;
  logic          capture_ready;
  logic [35:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overrun;
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0][35:0] words_t;
  typedef struct {
    logic [143:0] r0;
    logic [143:0] r1;
    words_t       exp;
    int           mode;   // 0: ready always 1, 1: ready 1,0,0,1 pattern, 2: random ready
  } vec_t;

  vec_t vecs [3];

  dsp_result_drain dut (
    .clk           (clk),
    .reset         (reset),
    .capture       (capture),
    .result0       (result0),
    .result1       (result1),
    .capture_ready (capture_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .overrun       (overrun),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // All tasks start just after a falling edge and return just after one.
  task automatic do_capture(input logic [143:0] a, input logic [143:0] b);
    result0 = a;
    result1 = b;
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
  endtask

  // Accept words first..stop-1 of a frame; every cycle the current word must
  // be valid and equal to the expected slice, which also proves stall stability.
  task automatic drain(input words_t exp, input int first, input int stop,
                       input int mode, input string tag);
    int k   = first;
    int cyc = 0;
    logic r;
    while (k < stop && cyc < 64) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = r;
      chk($sformatf("%s_valid_w%0d", tag, k), 64'(out_valid), 64'(1'b1));
      chk($sformatf("%s_data_w%0d", tag, k), 64'(out_data), 64'(exp[k]));
      chk($sformatf("%s_last_w%0d", tag, k), 64'(out_last), 64'(k == 7));
      if (r) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < stop) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout words=%0d required=%0d", tag, k, stop);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].r0   = 144'h1;
    vecs[0].r1   = {144{1'b1}};
    vecs[0].exp  = {36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF,
                    36'h0, 36'h0, 36'h0, 36'h1};
    vecs[0].mode = 0;
    vecs[1].r0   = {36'h4, 36'h3, 36'h2, 36'h1};
    vecs[1].r1   = {36'h8, 36'h7, 36'h6, 36'h5};
    vecs[1].exp  = {36'h8, 36'h7, 36'h6, 36'h5, 36'h4, 36'h3, 36'h2, 36'h1};
    vecs[1].mode = 1;
    vecs[2].r0   = 144'h012345678_9ABCDEF00_112233445_566778899;
    vecs[2].r1   = 144'hDEADBEEF0_123456789_A5A5A5A5A_000000001;
    vecs[2].exp  = {36'hD_EADB_EEF0, 36'h1_2345_6789, 36'hA_5A5A_5A5A, 36'h0_0000_0001,
                    36'h0_1234_5678, 36'h9_ABCD_EF00, 36'h1_1223_3445, 36'h5_6677_8899};
    vecs[2].mode = 2;

    reset     = 1'b1;
    capture   = 1'b0;
    out_ready = 1'b0;
    result0   = '0;
    result1   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    chk("rst_capture_ready", 64'(capture_ready), 64'(1));

    // Table: single frames under different ready patterns
    for (int i = 0; i < 3; i++) begin
      do_capture(vecs[i].r0, vecs[i].r1);
      drain(vecs[i].exp, 0, 8, vecs[i].mode, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_idle_after", i), 64'(out_valid), 64'(0));
      chk($sformatf("vec%0d_frame_count", i), 64'(frame_count), 64'(i + 1));
    end

    // Back-to-back captures: 16 consecutive valid words, no bubble
    out_ready = 1'b1;
    result0   = vecs[1].r0;
    result1   = vecs[1].r1;
    capture   = 1'b1;
    @(negedge clk);
    chk("b2b_first_valid", 64'(out_valid), 64'(1));
    chk("b2b_first_data", 64'(out_data), 64'(vecs[1].exp[0]));
    chk("b2b_second_ready", 64'(capture_ready), 64'(1));
    result0 = vecs[2].r0;
    result1 = vecs[2].r1;
    @(negedge clk);
    capture = 1'b0;
    drain(vecs[1].exp, 1, 8, 0, "b2b_a");
    drain(vecs[2].exp, 0, 8, 0, "b2b_b");
    chk("b2b_overrun", 64'(overrun), 64'(0));
    chk("b2b_frame_count", 64'(frame_count), 64'(5));
    chk("b2b_idle_after", 64'(out_valid), 64'(0));

    // Overrun: third capture while full is dropped
    out_ready = 1'b0;
    do_capture(vecs[0].r0, vecs[0].r1);
    chk("ovr_ready_after1", 64'(capture_ready), 64'(1));
    do_capture(vecs[1].r0, vecs[1].r1);
    chk("ovr_ready_after2", 64'(capture_ready), 64'(0));
    do_capture(vecs[2].r0, vecs[2].r1);
    chk("ovr_flag", 64'(overrun), 64'(1));
    chk("ovr_hold_data", 64'(out_data), 64'(vecs[0].exp[0]));
    drain(vecs[0].exp, 0, 8, 0, "ovr_f0");
    drain(vecs[1].exp, 0, 8, 0, "ovr_f1");
    chk("ovr_idle_after", 64'(out_valid), 64'(0));
    repeat (3) @(negedge clk);
    chk("ovr_still_idle", 64'(out_valid), 64'(0));
    chk("ovr_sticky", 64'(overrun), 64'(1));
    chk("ovr_frame_count", 64'(frame_count), 64'(7));

    // Capture coinciding with last-word pop at occupancy 1
    do_capture(vecs[1].r0, vecs[1].r1);
    drain(vecs[1].exp, 0, 7, 0, "sim_a");
    out_ready = 1'b1;
    result0   = vecs[2].r0;
    result1   = vecs[2].r1;
    capture   = 1'b1;
    chk("sim_last", 64'(out_last), 64'(1));
    chk("sim_last_data", 64'(out_data), 64'(vecs[1].exp[7]));
    @(negedge clk);
    capture = 1'b0;
    chk("sim_next_valid", 64'(out_valid), 64'(1));
    chk("sim_ready_occ1", 64'(capture_ready), 64'(1));
    drain(vecs[2].exp, 0, 8, 0, "sim_b");
    chk("sim_idle_after", 64'(out_valid), 64'(0));
    chk("sim_frame_count", 64'(frame_count), 64'(9));

    // Reset mid-frame after three words accepted
    do_capture(vecs[1].r0, vecs[1].r1);
    drain(vecs[1].exp, 0, 3, 0, "mid");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_frame_count", 64'(frame_count), 64'(0));
    chk("mid_rst_overrun", 64'(overrun), 64'(0));
    chk("mid_rst_ready", 64'(capture_ready), 64'(1));
    @(negedge clk);
    chk("mid_rst_still_idle", 64'(out_valid), 64'(0));
    do_capture(vecs[2].r0, vecs[2].r1);
    drain(vecs[2].exp, 0, 8, 1, "mid_new");
    chk("mid_new_frame_count", 64'(frame_count), 64'(1));

    // Capture while full is dropped even when the last word pops that cycle
    out_ready = 1'b0;
    do_capture(vecs[0].r0, vecs[0].r1);
    do_capture(vecs[1].r0, vecs[1].r1);
    drain(vecs[0].exp, 0, 7, 0, "full_pop_a");
    out_ready = 1'b1;
    result0   = vecs[2].r0;
    result1   = vecs[2].r1;
    capture   = 1'b1;
    chk("full_pop_ready", 64'(capture_ready), 64'(0));
    @(negedge clk);
    capture = 1'b0;
    chk("full_pop_overrun", 64'(overrun), 64'(1));
    drain(vecs[1].exp, 0, 8, 0, "full_pop_b");
    chk("full_pop_idle_after", 64'(out_valid), 64'(0));
    chk("full_pop_frame_count", 64'(frame_count), 64'(3));

    // frame_count wrap
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    chk("wrap_preload", 64'(frame_count), 64'(16'hFFFF));
    do_capture(vecs[0].r0, vecs[0].r1);
    drain(vecs[0].exp, 0, 8, 0, "wrap");
    chk("wrap_frame_count", 64'(frame_count), 64'(16'h0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_result_drain.md
DSP_RESULT_DRAIN -- requirements
Module: dsp_result_drain

Interface
REQ-001 Parameter DATA_W, default 144, width of each DSP half result.
REQ-002 Parameter OUT_W, default 36, width of output word; DATA_W SHALL be an integer multiple of OUT_W.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 capture  input  1  strobe: sample result0/result1 as one frame this cycle.
REQ-006 result0  input  DATA_W  first-half DSP result.
REQ-007 result1  input  DATA_W  second-half DSP result.
REQ-008 capture_ready  output  1  high when a frame slot is free.
REQ-009 out_data  output  OUT_W  serialized result word.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts word when out_valid & out_ready.
REQ-012 out_last  output  1  high with the final word of a frame.
REQ-013 overrun  output  1  sticky flag: a capture was dropped.
REQ-014 frame_count  output  16  count of fully drained frames, wraps 0xFFFF->0x0000.

Function
REQ-015 Frame = {result1, result0}, 2*DATA_W/OUT_W words (8 at defaults).
REQ-016 Word order: result0[OUT_W-1:0] first, ascending slices of result0, then ascending slices of result1; out_last on the final slice of result1[DATA_W-1:DATA_W-OUT_W].
REQ-017 Block SHALL hold a 2-entry frame buffer; capture_ready = (registered occupancy < 2).
REQ-018 capture with capture_ready high SHALL write the frame to the buffer on that edge.
REQ-019 capture with capture_ready low SHALL be dropped and set overrun, even if the last word is popped in the same cycle.
REQ-020 FSM states: IDLE (occupancy 0, out_valid low) and DRAIN (out_valid high, word index 0..N-1).
REQ-021 IDLE->DRAIN on the edge that accepts a capture; first word valid the next cycle (1-cycle latency).
REQ-022 In DRAIN, word index SHALL advance only on out_valid & out_ready; out_data, out_last SHALL hold stable while out_valid & !out_ready.
REQ-023 On handshake of the last word: frame popped, frame_count incremented, index reset to 0; if the other slot is occupied, word 0 of the next frame SHALL be valid the next cycle with no bubble, else go to IDLE.
REQ-024 Simultaneous capture and last-word pop with occupancy 1: both SHALL take effect; occupancy stays 1, draining continues with the new frame.
REQ-025 out_valid SHALL never drop before its word is accepted.

Reset
REQ-026 On reset: state IDLE, occupancy 0, word index 0, out_valid 0, out_last 0, out_data 0, overrun 0, frame_count 0, capture_ready 1 on the following cycle.
REQ-027 Reset mid-frame SHALL discard all buffered frames without emitting further words; overrun is cleared only by reset.

Structure
REQ-028 Shared package dsp_pkg SHALL hold DSP_RESULT_W=144, DRAIN_OUT_W=36, DRAIN_WORDS=8 and the FSM state enum.
REQ-029 The 2-entry frame buffer SHALL be a sub-module dsp_result_fifo2 (push, pop, occupancy, head frame); FSM, word mux and counters live in dsp_result_drain.

Verification
REQ-030 Single frame: result0=144'h1 (bit0), result1=all-ones, capture 1 cycle, out_ready=1 -> 8 words: 36'h1, 0, 0, 0, then 4x 36'hF_FFFF_FFFF, out_last on word 8, frame_count=1.
REQ-031 Backpressure: out_ready toggled 1,0,0,1,... -> out_data unchanged during stall cycles, all 8 words in order, no duplicates.
REQ-032 Back-to-back: capture frames A and B on consecutive cycles, out_ready=1 -> 16 consecutive valid cycles, B word0 immediately after A last, overrun=0.
REQ-033 Overrun: out_ready=0, capture 3 frames -> capture_ready low after 2nd, 3rd dropped, overrun=1 and stays 1; releasing out_ready drains exactly 2 frames.
REQ-034 Reset mid-frame: reset after word 3 of a frame -> out_valid=0 next cycle, frame_count=0, overrun=0; new capture drains from word 0.
REQ-035 Wrap: preload 0xFFFF drained frames (or force), drain one more -> frame_count=0x0000.
